// File: rtl/step_control_if.sv
// Board-side signal bundle for step_control: raw pushbuttons and rate
// switches in, processor clock-enable and status outputs back.
interface step_control_if;
  logic        key_step_n;
  logic        key_run_n;
  logic        key_cpu_rst_n;
  logic [1:0]  rate_sel;
  logic        step_pulse;
  logic        cpu_reset;
  logic        running;
  logic [15:0] step_count;

  modport master (
    output key_step_n, key_run_n, key_cpu_rst_n, rate_sel,
    input  step_pulse, cpu_reset, running, step_count
  );

  modport slave (
    input  key_step_n, key_run_n, key_cpu_rst_n, rate_sel,
    output step_pulse, cpu_reset, running, step_count
  );
endinterface

// File: rtl/step_control.sv
// Single-step / auto-run clock-enable generator for a soft processor:
// debounced pushbuttons, HALT/RUN FSM, rate-selectable period timer.
module step_control #(
  parameter int DB_CYCLES   = 1000000,
  parameter int BASE_PERIOD = 50000000
) (
  input  logic           clk,
  input  logic           reset_n,
  step_control_if.slave  bus
);

  localparam int DB_W  = (DB_CYCLES > 1)   ? $clog2(DB_CYCLES)   : 1;
  localparam int PER_W = (BASE_PERIOD > 1) ? $clog2(BASE_PERIOD) : 1;

  localparam int KEY_STEP = 0;
  localparam int KEY_RUN  = 1;
  localparam int KEY_RST  = 2;

  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

  typedef enum logic {
    HALT = 1'b0,
    RUN  = 1'b1
  } state_t;

  logic [2:0]            key_raw;
  logic [2:0]            sync1_q;
  logic [2:0]            sync2_q;
  logic [2:0]            db_level_q;
  logic [2:0]            press_q;
  logic [2:0][DB_W-1:0]  db_cnt_q;

  state_t                state_q;
  state_t                state_d;
  logic [PER_W-1:0]      period_q;
  logic [PER_W-1:0]      period_d;
  logic                  pulse_d;
  logic [15:0]           count_d;
  logic [31:0]           period_lim;
  logic                  period_hit;

  logic                  step_pulse_q;
  logic                  cpu_reset_q;
  logic                  running_q;
  logic [15:0]           step_count_q;

  assign key_raw = {bus.key_cpu_rst_n, bus.key_run_n, bus.key_step_n};

  // Keys idle high, so synchronizers and debounced levels reset to 1 and a
  // key already held at reset release is only seen after a full debounce.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q    <= '1;
      sync2_q    <= '1;
      db_level_q <= '1;
      press_q    <= '0;
      // NOTE: the debounce counters are plain flops, not a RAM, so they are
      // reset with everything else and cost nothing extra to clear.
      db_cnt_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments keep sync2_q reading last cycle's
      // sync1_q; blocking here would collapse the synchronizer to one flop.
      sync1_q <= key_raw;
      sync2_q <= sync1_q;
      press_q <= '0;
      for (int k = 0; k < 3; k++) begin
        if (sync2_q[k] != db_level_q[k]) begin
          if (db_cnt_q[k] == DB_LAST) begin
            db_level_q[k] <= sync2_q[k];
            db_cnt_q[k]   <= '0;
            press_q[k]    <= ~sync2_q[k];
          end else begin
            db_cnt_q[k] <= db_cnt_q[k] + DB_W'(1);
          end
        end else begin
          db_cnt_q[k] <= '0;
        end
      end
    end
  end

  // Period limit is recomputed every cycle, so a rate change lands at once.
  assign period_lim = (32'(BASE_PERIOD) >> {bus.rate_sel, 1'b0}) - 32'd1;
  assign period_hit = 32'(period_q) >= period_lim;

  always_comb begin
    // NOTE: every output of this block is defaulted first so no path through
    // the case leaves a value unassigned and no latch is inferred.
    state_d  = state_q;
    period_d = period_q;
    pulse_d  = 1'b0;
    if (cpu_reset_q) begin
      state_d  = HALT;
      period_d = '0;
    end else begin
      unique case (state_q)
        HALT: begin
          if (press_q[KEY_RUN]) begin
            state_d  = RUN;
            period_d = '0;
          end else begin
            pulse_d = press_q[KEY_STEP];
          end
        end
        RUN: begin
          if (press_q[KEY_RUN]) begin
            state_d  = HALT;
            period_d = '0;
          end else if (period_hit) begin
            pulse_d  = 1'b1;
            period_d = '0;
          end else begin
            period_d = period_q + PER_W'(1);
          end
        end
        default: state_d = HALT;
      endcase
    end
    count_d = cpu_reset_q ? 16'd0 : step_count_q + 16'(pulse_d);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= HALT;
      period_q     <= '0;
      step_pulse_q <= 1'b0;
      cpu_reset_q  <= 1'b0;
      running_q    <= 1'b0;
      step_count_q <= '0;
    end else begin
      state_q      <= state_d;
      period_q     <= period_d;
      step_pulse_q <= pulse_d;
      cpu_reset_q  <= ~db_level_q[KEY_RST];
      running_q    <= (state_d == RUN);
      step_count_q <= count_d;
    end
  end

  assign bus.step_pulse = step_pulse_q;
  assign bus.cpu_reset  = cpu_reset_q;
  assign bus.running    = running_q;
  assign bus.step_count = step_count_q;

endmodule

// File: doc/step_control.md
STEP_CONTROL -- requirements
Module: step_control

Interface
REQ-001 Parameter DB_CYCLES, default 1000000, is the number of consecutive stable clk cycles required to accept a key level change (20 ms at 50 MHz).
REQ-002 Parameter BASE_PERIOD, default 50000000, is the auto-run step period in clk cycles at rate_sel=0.
REQ-003 Port clk, input, 1, is the board clock (CLOCK_50); it is the only clock.
REQ-004 Port reset_n, input, 1, is the block reset, asynchronous and active-low.
REQ-005 Port key_step_n, input, 1, is the raw single-step pushbutton, asynchronous, active-low, bouncing.
REQ-006 Port key_run_n, input, 1, is the raw run/halt toggle pushbutton, asynchronous, active-low.
REQ-007 Port key_cpu_rst_n, input, 1, is the raw processor-reset pushbutton, asynchronous, active-low.
REQ-008 Port rate_sel, input, 2, is the auto-run rate select from the switches.
REQ-009 Port step_pulse, output, 1, is a one-clk-wide processor clock-enable pulse.
REQ-010 Port cpu_reset, output, 1, is the active-high processor reset level.
REQ-011 Port running, output, 1, is high in RUN state and drives a status LED.
REQ-012 Port step_count, output, 16, is the number of step_pulse events since the last reset.

Function
REQ-013 Each key input SHALL pass through a 2-flop synchronizer preset to 1.
REQ-014 Each synchronized key SHALL have a debounced level, initially 1, which takes the synchronized value only after that value has differed from it for DB_CYCLES consecutive cycles; any return to the debounced value restarts the count at 0.
REQ-015 A press event SHALL be a 1->0 transition of a debounced level, lasting one cycle; releases generate no event.
REQ-016 The FSM SHALL have exactly two states, HALT and RUN, and a run press event SHALL toggle between them.
REQ-017 In HALT, a step press event SHALL assert step_pulse on the next clk cycle for exactly one cycle, however long the key is held.
REQ-018 In RUN, step press events SHALL be ignored.
REQ-019 In RUN, a period counter SHALL count from 0 and assert step_pulse for one cycle when it is >= (BASE_PERIOD >> (2*rate_sel)) - 1, then reload to 0.
REQ-020 Entering RUN SHALL clear the period counter, so the first auto pulse occurs a full period later; entering HALT SHALL clear the counter and emit no pulse.
REQ-021 A rate_sel change during RUN SHALL take effect immediately via the >= compare, with no wait for wrap.
REQ-022 When step and run press events occur in the same cycle, only the run toggle SHALL take effect.
REQ-023 cpu_reset SHALL equal the inverse of the debounced key_cpu_rst_n level, registered.
REQ-024 While cpu_reset is high: step_pulse=0, state forced to HALT, period counter=0, step_count=0, and press events ignored.
REQ-025 step_count SHALL increment by 1 on every step_pulse and wrap from 0xFFFF to 0x0000.
REQ-026 All outputs SHALL be registered.

Reset
REQ-027 While reset_n=0 the block SHALL asynchronously force: step_pulse=0, cpu_reset=0, running=0, step_count=0, state HALT, counters 0, synchronizers and debounced levels 1.
REQ-028 Deasserting reset_n mid-press SHALL produce no event until the key is released and pressed again, or until a held press is accepted after DB_CYCLES.

Verification (DB_CYCLES=4, BASE_PERIOD=64)
REQ-029 Hold key_step_n=0 for 30 cycles after reset -> exactly one step_pulse, 6-8 cycles after assertion; step_count=1.
REQ-030 Toggle key_step_n every 2 cycles for 12 cycles, then hold 0 -> exactly one step_pulse; step_count=1.
REQ-031 Run press with rate_sel=0 -> running=1, pulses 64 cycles apart; set rate_sel=2 mid-period -> next pulse within 4 cycles, then every 4.
REQ-032 Press key_cpu_rst_n during RUN with step_count=5 -> cpu_reset=1, running=0, step_count=0, no pulses while held; after release, a step press gives step_count=1.
REQ-033 Set rate_sel=3 in RUN (period 1) for 65536 cycles -> step_pulse high every cycle; step_count wraps to 0x0000.
REQ-034 Assert reset_n=0 mid-RUN -> all outputs 0 in the same cycle, before any clk edge.
